// File: rtl/btn_conditioner.sv
// Per-button conditioner: 2-flop sync, counter debounce, press/release/auto-repeat pulses.
// Latency: press/release pulses appear DEBOUNCE_CYCLES+3 edges after the input settles. There is no backpressure.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk100_i,
  input  logic rstn_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int REP_W = $clog2(REP_MAX) + 1;
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;
  typedef enum logic {PH_DELAY, PH_PERIOD} phase_t;

  logic             sync0;
  logic             sync1;
  logic             btn_s;
  state_t           state;
  state_t           state_n;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] deb_cnt_n;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_n;
  phase_t           rep_phase;
  phase_t           rep_phase_n;
  logic [REP_W-1:0] rep_last;
  logic             press_n;
  logic             release_n;
  logic             repeat_n;
  logic             level_n;

  // Input is inverted on entry so the core works with 1 = pressed.
  assign btn_s    = sync1;
  assign rep_last = (rep_phase == PH_DELAY) ? DELAY_LAST : PERIOD_LAST;

  always_comb begin
    state_n     = state;
    deb_cnt_n   = deb_cnt;
    rep_cnt_n   = rep_cnt;
    rep_phase_n = rep_phase;
    press_n     = 1'b0;
    release_n   = 1'b0;
    repeat_n    = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n   = PRESS_CHK;
          deb_cnt_n = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_n     = HELD;
          press_n     = 1'b1;
          rep_cnt_n   = '0;
          rep_phase_n = PH_DELAY;
        end else begin
          deb_cnt_n = deb_cnt + DEB_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_n   = RELEASE_CHK;
          deb_cnt_n = '0;
        end else if (REPEAT_EN != 0) begin
          if (rep_cnt == rep_last) begin
            rep_cnt_n   = '0;
            rep_phase_n = PH_PERIOD;
            repeat_n    = 1'b1;
          end else begin
            rep_cnt_n = rep_cnt + REP_W'(1);
          end
        end
      end
      RELEASE_CHK: begin
        // A bounce back to pressed resumes the repeat schedule where it paused.
        if (btn_s) begin
          state_n   = HELD;
          deb_cnt_n = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end else begin
          deb_cnt_n = deb_cnt + DEB_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    level_n = (state_n == HELD) || (state_n == RELEASE_CHK);
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync0     <= 1'b0;
      sync1     <= 1'b0;
      state     <= IDLE;
      deb_cnt   <= '0;
      rep_cnt   <= '0;
      rep_phase <= PH_DELAY;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      repeat_o  <= 1'b0;
    end else begin
      sync0     <= ~btn_i;
      sync1     <= sync0;
      state     <= state_n;
      deb_cnt   <= deb_cnt_n;
      rep_cnt   <= rep_cnt_n;
      rep_phase <= rep_phase_n;
      level_o   <= level_n;
      press_o   <= press_n;
      release_o <= release_n;
      repeat_o  <= repeat_n;
    end
  end

endmodule
